// File: rtl/fir_pkg.sv
// Shared widths, controller state and result-FIFO entry for the FIR streaming path.
package fir_pkg;

  localparam int unsigned BIT_PREC = 16;
  localparam int unsigned TAPS     = 8;
  localparam int unsigned OUT_W    = 2 * BIT_PREC + TAPS - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fir_ctrl_state_t;

  typedef struct packed {
    logic             last;
    logic [OUT_W-1:0] data;
  } fir_res_t;

endpackage

// File: rtl/fir_res_fifo.sv
// Synchronous result FIFO with a registered occupancy count; full/empty derive from that count only.
module fir_res_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fir_stream_ctrl.sv
// Valid/ready streaming controller for the FIR datapath with an output result FIFO.
// Tail flushing with zero samples is enabled by defining FIR_STREAM_CTRL_TAIL_FLUSH_EN.
module fir_stream_ctrl #(
  parameter int unsigned BIT_PREC   = fir_pkg::BIT_PREC,
  parameter int unsigned TAPS       = fir_pkg::TAPS,
  parameter int unsigned OUT_W      = 2 * BIT_PREC + TAPS - 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [BIT_PREC-1:0] s_data,
  input  logic                s_last,
  output logic                fir_en,
  output logic [BIT_PREC-1:0] fir_in,
  input  logic [OUT_W-1:0]    fir_out,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [OUT_W-1:0]    m_data,
  output logic                m_last,
  output logic                busy
);

  import fir_pkg::*;

  // Same layout as fir_res_t, sized by this instance's OUT_W.
  typedef struct packed {
    logic             last;
    logic [OUT_W-1:0] data;
  } res_t;

  fir_ctrl_state_t state_q;
  fir_ctrl_state_t state_d;
  logic            space;
  logic            accept;
  logic            issue;
  logic            push_last;
  logic            fifo_full;
  logic            fifo_empty;
  res_t            push_entry;
  res_t            head;

`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
  localparam int unsigned FCW = (TAPS > 2) ? $clog2(TAPS) : 1;
  logic [FCW-1:0] flush_cnt_q;
  logic [FCW-1:0] flush_cnt_d;
`endif

  assign space   = !fifo_full;
  assign s_ready = space && ((state_q == IDLE) || (state_q == RUN));
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    push_last = 1'b0;
`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
    flush_cnt_d = flush_cnt_q;
`endif
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          issue = 1'b1;
`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
          if (s_last) begin
            state_d     = FLUSH;
            flush_cnt_d = FCW'(TAPS - 2);
          end else begin
            state_d = RUN;
          end
`else
          state_d   = s_last ? IDLE : RUN;
          push_last = s_last;
`endif
        end
      end
`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
      // Counter holds the number of zero samples still to issue after this one.
      FLUSH: begin
        if (space) begin
          issue = 1'b1;
          if (flush_cnt_q == '0) begin
            state_d   = IDLE;
            push_last = 1'b1;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end
`endif

  assign fir_en = issue;
  assign fir_in = accept ? s_data : '0;
  assign busy   = (state_q != IDLE);

  assign push_entry.last = push_last;
  assign push_entry.data = fir_out;

  fir_res_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (res_t)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (push_entry),
    .pop       (m_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? head.data : '0;
  assign m_last  = m_valid && head.last;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Self-checking bench for fir_stream_ctrl with a behavioural 4-tap FIR datapath {1,2,3,4}.
module tb_fir_stream_ctrl;

  localparam int unsigned BP = 8;
  localparam int unsigned TP = 4;
  localparam int unsigned OW = 2 * BP + TP - 1;
  localparam int unsigned FD = 4;
`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
  localparam int TAIL = TP - 1;
`else
  localparam int TAIL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [BP-1:0] s_data;
  logic          s_last;
  logic          fir_en;
  logic [BP-1:0] fir_in;
  logic [OW-1:0] fir_out;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          m_last;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fir_stream_ctrl #(
    .BIT_PREC   (BP),
    .TAPS       (TP),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .fir_en  (fir_en),
    .fir_in  (fir_in),
    .fir_out (fir_out),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy)
  );

  // Datapath stand-in: combinational in fir_in, delay line advances on fir_en, shares rst.
  logic signed [BP-1:0] d0, d1, d2;
  always @(posedge clk) begin
    if (rst) begin
      d0 <= '0; d1 <= '0; d2 <= '0;
    end else if (fir_en) begin
      d0 <= fir_in; d1 <= d0; d2 <= d1;
    end
  end
  always_comb fir_out = OW'($signed(fir_in) + 2 * d0 + 3 * d1 + 4 * d2);

  // Reference model: convolution of the sample history with h.
  int h [4] = '{1, 2, 3, 4};
  int hist [$];
  int exp_d [$];
  bit exp_l [$];
  int frame_len_q [$];
  int got_d [$];
  bit got_l [$];
  int lit_d [$];
  bit lit_l [$];
  int cur_len = 0;
  int pops_in_frame = 0;
  int lasts_seen = 0;
  int issues = 0;
  int accepts = 0;
  bit rand_ready = 1'b0;

  function automatic int conv_at(input int x [$], input int n);
    int acc = 0;
    for (int k = 0; k < 4; k++) begin
      if (n - k >= 0 && n - k < x.size()) acc += h[k] * x[n - k];
    end
    return acc;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_d.delete(); exp_l.delete(); frame_len_q.delete(); hist.delete();
      cur_len = 0; pops_in_frame = 0;
    end else begin
      if (m_valid) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL stream: unexpected result m_data=%0d m_last=%0b, none required",
                   int'($signed(m_data)), m_last);
        end else if (int'($signed(m_data)) != exp_d[0] || m_last != exp_l[0]) begin
          errors++;
          $display("FAIL stream: got m_data=%0d m_last=%0b, required %0d/%0b",
                   int'($signed(m_data)), m_last, exp_d[0], exp_l[0]);
        end
        if (m_ready && exp_d.size() != 0) begin
          got_d.push_back(int'($signed(m_data)));
          got_l.push_back(m_last);
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
          pops_in_frame++;
          if (m_last) begin
            lasts_seen++;
            checks++;
            if (frame_len_q.size() == 0 || frame_len_q[0] != pops_in_frame) begin
              errors++;
              $display("FAIL frame_results: got %0d results in frame, required %0d",
                       pops_in_frame, (frame_len_q.size() != 0) ? frame_len_q[0] : -1);
            end
            if (frame_len_q.size() != 0) void'(frame_len_q.pop_front());
            pops_in_frame = 0;
          end
        end
      end
      if (s_valid && s_ready) begin
        checks++;
        if (fir_en !== 1'b1 || fir_in !== s_data) begin
          errors++;
          $display("FAIL issue: fir_en=%0b fir_in=%0d, required 1/%0d", fir_en, fir_in, s_data);
        end
        accepts++;
        cur_len++;
        hist.push_back(int'($signed(s_data)));
        exp_d.push_back(conv_at(hist, hist.size() - 1));
`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
        exp_l.push_back(1'b0);
        if (s_last) begin
          for (int n = hist.size(); n < hist.size() + TAIL; n++) begin
            exp_d.push_back(conv_at(hist, n));
            exp_l.push_back(n == hist.size() + TAIL - 1);
          end
          frame_len_q.push_back(cur_len + TAIL);
          hist.delete();
          cur_len = 0;
        end
`else
        exp_l.push_back(s_last);
        if (s_last) begin
          frame_len_q.push_back(cur_len);
          cur_len = 0;
        end
`endif
      end
      if (fir_en) issues++;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input int v, input bit last, input int gap);
    int n = 0;
    bit acc = 1'b0;
    repeat (gap) step();
    s_valid = 1'b1; s_data = BP'(v); s_last = last;
    do begin
      @(negedge clk);
      acc = s_ready;
      step();
      n++;
    end while (!acc && n < 1000);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send: sample %0d not accepted within %0d cycles", v, n);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(negedge clk);
    while ((exp_d.size() != 0 || m_valid || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s drain: %0d results still outstanding, required 0", name, exp_d.size());
    end
    step();
  endtask

  task automatic check_seq(input string name);
    chk({name, " count"}, got_d.size(), lit_d.size());
    for (int i = 0; i < lit_d.size() && i < got_d.size(); i++) begin
      chk({name, " data"}, got_d[i], lit_d[i]);
      chk({name, " last"}, int'(got_l[i]), int'(lit_l[i]));
    end
  endtask

  task automatic clear_log();
    got_d.delete(); got_l.delete();
    issues = 0; accepts = 0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("reset s_ready", s_ready, 1);
    chk("reset m_valid", m_valid, 0);
    chk("reset m_data", int'(m_data), 0);
    chk("reset m_last", m_last, 0);
    chk("reset fir_en", fir_en, 0);
    chk("reset fir_in", int'(fir_in), 0);
    chk("reset busy", busy, 0);
    step();

    // Impulse frame
    clear_log();
    send(1, 1'b1, 0);
    @(negedge clk);
    chk("impulse latency m_valid", m_valid, 1);
    chk("impulse first m_data", int'($signed(m_data)), 1);
    chk("impulse busy", busy, (TAIL != 0) ? 1 : 0);
    step();
    drain("impulse");
    chk("impulse busy after", busy, 0);
`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
    lit_d = '{1, 2, 3, 4}; lit_l = '{0, 0, 0, 1};
`else
    lit_d = '{1}; lit_l = '{1};
`endif
    check_seq("impulse");
    chk("impulse issues", issues, 1 + TAIL);

    // Two back-to-back frames
    do_reset();
    clear_log();
    send(2, 1'b0, 0);
    send(0, 1'b0, 0);
    send(-1, 1'b1, 0);
    send(1, 1'b1, 0);
    drain("two_frames");
`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
    lit_d = '{2, 4, 5, 6, -3, -4, 1, 2, 3, 4}; lit_l = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
`else
    lit_d = '{2, 4, 5, 7}; lit_l = '{0, 0, 1, 1};
`endif
    check_seq("two_frames");
    chk("two_frames issues", issues, 4 + 2 * TAIL);

    // Output stalled: FIFO fills after FD accepts
    do_reset();
    clear_log();
    m_ready = 1'b0;
    send(3, 1'b0, 0);
    send(-2, 1'b0, 0);
    send(5, 1'b0, 0);
    send(1, 1'b0, 0);
    s_valid = 1'b1; s_data = BP'(-4); s_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall s_ready", s_ready, 0);
      chk("stall fir_en", fir_en, 0);
    end
    chk("stall accepts", accepts, FD);
    step();
    m_ready = 1'b1;
    send(-4, 1'b0, 0);
    send(7, 1'b1, 0);
    drain("stall");
    chk("stall result count", got_d.size(), 6 + TAIL);

    // Reset in the middle of a frame
    do_reset();
    clear_log();
`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
    send(1, 1'b1, 0);
    step();
`else
    send(5, 1'b0, 0);
    send(6, 1'b0, 0);
`endif
    chk("midreset issues before rst", issues, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midreset busy", busy, 0);
    chk("midreset m_valid", m_valid, 0);
    chk("midreset s_ready", s_ready, 1);
    step();
    clear_log();
    send(1, 1'b1, 0);
    drain("after_reset");
`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
    lit_d = '{1, 2, 3, 4}; lit_l = '{0, 0, 0, 1};
`else
    lit_d = '{1}; lit_l = '{1};
`endif
    check_seq("after_reset");

    // Two-sample frame
    do_reset();
    clear_log();
    send(1, 1'b0, 0);
    send(1, 1'b1, 0);
    drain("pair");
`ifdef FIR_STREAM_CTRL_TAIL_FLUSH_EN
    lit_d = '{1, 3, 5, 7, 4}; lit_l = '{0, 0, 0, 0, 1};
`else
    lit_d = '{1, 3}; lit_l = '{0, 1};
`endif
    check_seq("pair");
    chk("pair issues", issues, 2 + TAIL);

    // Random frames with random handshakes
    do_reset();
    clear_log();
    lasts_seen = 0;
    rand_ready = 1'b1;
    for (int f = 0; f < 200; f++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        send(int'($urandom_range(0, 255)) - 128, i == len - 1, $urandom_range(0, 2));
      end
    end
    drain("random");
    rand_ready = 1'b0;
    step();
    m_ready = 1'b1;
    chk("random frames", lasts_seen, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
